// File: rtl/mempool_tcdm_reorder_buffer.sv
// Tags remote TCDM requests with a ROB slot and returns NoC responses to the tile in request order.
// Latency: request path 0 cycles; a captured response is visible one cycle later when its slot is the head.
// Backpressure: requests stall while all slots are allocated; the tile may hold rsp_ready low indefinitely.
module mempool_tcdm_reorder_buffer #(
    parameter int unsigned NumOutstanding = 8,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    localparam int unsigned BeWidth       = DataWidth / 8,
    localparam int unsigned IdWidth       = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_wen_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 noc_req_valid_o,
    input  logic                 noc_req_ready_i,
    output logic [AddrWidth-1:0] noc_req_addr_o,
    output logic                 noc_req_wen_o,
    output logic [DataWidth-1:0] noc_req_wdata_o,
    output logic [BeWidth-1:0]   noc_req_be_o,
    output logic [IdWidth-1:0]   noc_req_id_o,
    input  logic                 noc_rsp_valid_i,
    output logic                 noc_rsp_ready_o,
    input  logic [IdWidth-1:0]   noc_rsp_id_i,
    input  logic [DataWidth-1:0] noc_rsp_rdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic [IdWidth:0]     occupancy_o,
    output logic                 err_o
);

    logic [IdWidth:0]          wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, occupancy;
    logic [IdWidth-1:0]        wr_idx, rd_idx;
    logic [NumOutstanding-1:0] pending, done;
    logic [DataWidth-1:0]      slot_data [NumOutstanding];
    logic                      full, alloc, capture, rsp_fire, err;

    assign wr_idx = wr_ptr[IdWidth-1:0];
    assign rd_idx = rd_ptr[IdWidth-1:0];
    assign full   = (wr_ptr[IdWidth] != rd_ptr[IdWidth]) && (wr_idx == rd_idx);

    // Valid toward the chimney deliberately ignores its ready to keep the handshake acyclic.
    assign noc_req_valid_o = req_valid_i & ~full;
    assign req_ready_o     = noc_req_ready_i & ~full;
    assign noc_req_addr_o  = req_addr_i;
    assign noc_req_wen_o   = req_wen_i;
    assign noc_req_wdata_o = req_wdata_i;
    assign noc_req_be_o    = req_be_i;
    assign noc_req_id_o    = wr_idx;
    assign noc_rsp_ready_o = 1'b1;

    assign alloc    = req_valid_i & req_ready_o;
    assign capture  = noc_rsp_valid_i & pending[noc_rsp_id_i] & ~done[noc_rsp_id_i];
    assign rsp_fire = rsp_valid_o & rsp_ready_i;

    assign rsp_valid_o = done[rd_idx];
    assign rsp_rdata_o = slot_data[rd_idx];
    assign occupancy_o = occupancy;
    assign err_o       = err;

    assign wr_ptr_next = wr_ptr + (IdWidth+1)'(alloc);
    assign rd_ptr_next = rd_ptr + (IdWidth+1)'(rsp_fire);

    // Alloc, capture and release always target distinct slots, so their updates never collide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            pending   <= '0;
            done      <= '0;
            err       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            occupancy <= wr_ptr_next - rd_ptr_next;
            if (alloc) begin
                pending[wr_idx] <= 1'b1;
                done[wr_idx]    <= 1'b0;
            end
            if (capture) begin
                done[noc_rsp_id_i] <= 1'b1;
            end
            if (rsp_fire) begin
                pending[rd_idx] <= 1'b0;
                done[rd_idx]    <= 1'b0;
            end
            if (noc_rsp_valid_i && !capture) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            slot_data[noc_rsp_id_i] <= noc_rsp_rdata_i;
        end
    end

    a_no_alloc_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(alloc && full));

    a_req_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (noc_req_valid_o && !noc_req_ready_i) |=> (noc_req_valid_o &&
        $stable({noc_req_addr_o, noc_req_wen_o, noc_req_wdata_o, noc_req_be_o, noc_req_id_o})));

    a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_rdata_o)));

endmodule
